mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch (IF) and an execute (EX) requester onto one memory port, with a wait timeout.
// Optional IF anti-starvation is enabled by defining MEM_ARB_ANTI_STARVE_EN.

module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned WAIT_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        ex_req,
  input  logic        ex_we,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic [31:0] ex_rdata,
  output logic        ex_ack,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int unsigned WaitW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [1:0] {StIdle, StGntIf, StGntEx} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      ex_rdata_q, ex_rdata_d;
  logic             if_ack_q, if_ack_d;
  logic             ex_ack_q, ex_ack_d;
  logic             err_q, err_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             grant_if, grant_ex;

`ifdef MEM_ARB_ANTI_STARVE_EN
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  logic [StarveW-1:0] starve_q, starve_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    ex_rdata_d = ex_rdata_q;
    if_ack_d   = 1'b0;
    ex_ack_d   = 1'b0;
    err_d      = err_q;
    wait_d     = wait_q;
    grant_if   = 1'b0;
    grant_ex   = 1'b0;
`ifdef MEM_ARB_ANTI_STARVE_EN
    starve_d   = starve_q;
`endif

    unique case (state_q)
      StIdle: begin
        // The ack cycle is a turnaround: nothing is granted, so a held req is not re-served
        // and arbitration restarts from a clean IDLE on the following cycle.
        if (!if_ack_q && !ex_ack_q) begin
`ifdef MEM_ARB_ANTI_STARVE_EN
          grant_ex = ex_req && !(if_req && (starve_q == StarveW'(STARVE_MAX)));
`else
          grant_ex = ex_req;
`endif
          grant_if = if_req && !grant_ex;
        end
        if (grant_ex) begin
          state_d = StGntEx;
          addr_d  = ex_addr;
          wdata_d = ex_wdata;
          we_d    = ex_we;
          wait_d  = '0;
`ifdef MEM_ARB_ANTI_STARVE_EN
          if (if_req) starve_d = starve_q + 1'b1;
`endif
        end else if (grant_if) begin
          state_d = StGntIf;
          addr_d  = if_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          wait_d  = '0;
`ifdef MEM_ARB_ANTI_STARVE_EN
          starve_d = '0;
`endif
        end
      end

      StGntIf, StGntEx: begin
        if (mem_ready || (wait_q == WaitW'(WAIT_MAX - 1))) begin
          // Timeout completes the access with zero data and latches the error.
          state_d = StIdle;
          wait_d  = '0;
          if (!mem_ready) err_d = 1'b1;
          if (state_q == StGntEx) begin
            ex_ack_d   = 1'b1;
            ex_rdata_d = mem_ready ? mem_rdata : 32'h0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : 32'h0;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      ex_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      ex_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= '0;
`ifdef MEM_ARB_ANTI_STARVE_EN
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      ex_rdata_q <= ex_rdata_d;
      if_ack_q   <= if_ack_d;
      ex_ack_q   <= ex_ack_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
`ifdef MEM_ARB_ANTI_STARVE_EN
      starve_q   <= starve_d;
`endif
    end
  end

  assign mem_req   = (state_q != StIdle);
  assign mem_we    = we_q & mem_req;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign ex_rdata  = ex_rdata_q;
  assign if_ack    = if_ack_q;
  assign ex_ack    = ex_ack_q;
  assign err       = err_q;
  assign stall     = (if_req & ~if_ack_q) | (ex_req & ~ex_ack_q);

endmodule
